// File: rtl/lfsr_sequence_checker_if.sv
// Word stream into the sequence checker and its registered status back out.
// The master drives words; the slave (checker) reports lock, prediction and error stats.
interface lfsr_sequence_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic             in_valid;
  logic [8:0]       in_data;
  logic             clr_count;
  logic             locked;
  logic [8:0]       expected;
  logic             match_pulse;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output in_valid, in_data, clr_count,
    input  locked, expected, match_pulse, err_pulse, err_count, state
  );

  modport slave (
    input  in_valid, in_data, clr_count,
    output locked, expected, match_pulse, err_pulse, err_count, state
  );
endinterface

// File: rtl/lfsr_sequence_checker.sv
// Self-synchronising checker for the 9-bit scrambler sequence: seeds from the stream,
// verifies LOCK_COUNT words, then flywheels and counts word errors. All outputs registered.
module lfsr_sequence_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  lfsr_sequence_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

  function automatic logic [8:0] lfsr_next(input logic [8:0] d);
    logic [8:0] n;
    n[8] = d[8] ^ d[1];
    n[7] = d[7] ^ d[0];
    n[6] = d[6] ^ d[8];
    n[5] = d[5] ^ d[7];
    n[4] = d[4] ^ d[6];
    n[3] = d[3] ^ d[5];
    // low bits fold in already-computed upper outputs
    n[2] = d[2] ^ n[4];
    n[1] = d[1] ^ n[3];
    n[0] = d[0] ^ n[2];
    return n;
  endfunction

  state_t           state_q, state_d;
  logic [8:0]       pred_q, pred_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             locked_q;

  logic       word_zero;
  logic       word_hit;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic [8:0] seed_next;
  logic [8:0] fly_next;

  assign word_zero = (bus.in_data == 9'd0);
  assign word_hit  = (bus.in_data == pred_q);
  assign good_inc  = good_cnt_q + 4'd1;
  assign bad_inc   = bad_cnt_q + 4'd1;
  assign seed_next = lfsr_next(bus.in_data);
  assign fly_next  = lfsr_next(pred_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      pred_q     <= 9'd0;
      good_cnt_q <= 4'd0;
      bad_cnt_q  <= 4'd0;
      err_cnt_q  <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      err_cnt_q  <= err_cnt_d;
      match_q    <= match_d;
      err_q      <= err_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (!word_zero) state_d = VERIFY;
        end
        VERIFY: begin
          if (word_hit) begin
            if (good_inc == LOCK_CNT) state_d = LOCKED;
          end else if (word_zero) begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (!word_hit && (bad_inc == LOSS_CNT)) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    pred_d     = pred_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    err_cnt_d  = err_cnt_q;
    match_d    = 1'b0;
    err_d      = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (!word_zero) begin
            pred_d     = seed_next;
            good_cnt_d = 4'd0;
          end
        end
        VERIFY: begin
          if (word_hit) begin
            match_d    = 1'b1;
            pred_d     = seed_next;
            good_cnt_d = good_inc;
            if (good_inc == LOCK_CNT) bad_cnt_d = 4'd0;
          end else if (!word_zero) begin
            pred_d     = seed_next;
            good_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          // flywheel: the received word never reseeds the predictor here
          if (word_hit) begin
            match_d   = 1'b1;
            bad_cnt_d = 4'd0;
            pred_d    = fly_next;
          end else begin
            err_d     = 1'b1;
            bad_cnt_d = bad_inc;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (bad_inc != LOSS_CNT) pred_d = fly_next;
          end
        end
        default: ;
      endcase
    end
    if (bus.clr_count) err_cnt_d = '0;
  end

  always_comb begin
    bus.state       = state_q;
    bus.locked      = locked_q;
    bus.expected    = pred_q;
    bus.match_pulse = match_q;
    bus.err_pulse   = err_q;
    bus.err_count   = err_cnt_q;
  end

  a_locked_tracks_state : assert property (@(posedge clk) disable iff (rst)
    locked_q == (state_q == LOCKED));
  a_pulses_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(match_q && err_q));

endmodule
